// File: rtl/led_status_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// led_status_pkg
// Shared types and default constants for the LED status controller.
//   led_mode_t         : per-channel LED mode (OFF / ON / BLINK / ACTIVITY)
//   DEF_PRESCALE       : clk cycles per tick (1 ms at 64 MHz)
//   DEF_PERIOD_W       : width of the blink half-period field, in ticks
//   DEF_STRETCH_TICKS  : activity pulse-stretch length, in ticks
// -----------------------------------------------------------------------------
package led_status_pkg;

   typedef enum logic [1:0] {
      MODE_OFF      = 2'd0,
      MODE_ON       = 2'd1,
      MODE_BLINK    = 2'd2,
      MODE_ACTIVITY = 2'd3
   } led_mode_t;

   localparam int DEF_PRESCALE      = 64000;
   localparam int DEF_PERIOD_W      = 10;
   localparam int DEF_STRETCH_TICKS = 50;

endpackage

// File: rtl/led_status_ctrl_if.sv
// -----------------------------------------------------------------------------
// led_status_ctrl_if
// Configuration write bus of the LED status controller.
//   cfg_we     : one-cycle write strobe
//   cfg_ch     : channel index of the write (indices >= NUM_CH are ignored)
//   cfg_mode   : new channel mode
//   cfg_period : new blink half-period, in ticks
//   cfg_duty   : new PWM duty, 0..15 (only when LED_PWM_EN is defined)
// Modports: master drives the bus, slave (the controller) receives it.
// -----------------------------------------------------------------------------
interface led_status_ctrl_if
   import led_status_pkg::*;
#(
   parameter int NUM_CH   = 6,
   parameter int PERIOD_W = DEF_PERIOD_W
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic                cfg_we;
   logic [CH_W-1:0]     cfg_ch;
   led_mode_t           cfg_mode;
   logic [PERIOD_W-1:0] cfg_period;
`ifdef LED_PWM_EN
   logic [3:0]          cfg_duty;
`endif

   modport master (
      output cfg_we,
      output cfg_ch,
      output cfg_mode,
`ifdef LED_PWM_EN
      output cfg_duty,
`endif
      output cfg_period
   );

   modport slave (
      input cfg_we,
      input cfg_ch,
      input cfg_mode,
`ifdef LED_PWM_EN
      input cfg_duty,
`endif
      input cfg_period
   );

endinterface

// File: rtl/led_status_ctrl_ch.sv
// -----------------------------------------------------------------------------
// led_status_ch
// One LED channel: activity synchroniser and edge detector, blink counter,
// activity pulse stretcher and (with LED_PWM_EN) a duty register.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   i_act       : asynchronous activity input
//   i_evtMask   : suppresses edge events (reset and just after it)
//   i_tick      : prescaler tick pulse
//   i_wrEn      : configuration write aimed at this channel
//   i_mode      : mode to load on a write
//   i_period    : blink half-period to load on a write
//   i_duty      : PWM duty to load on a write      (LED_PWM_EN only)
//   i_pwmCnt    : shared free-running PWM counter  (LED_PWM_EN only)
//   o_lit       : channel is lit (before output polarity and register)
// -----------------------------------------------------------------------------
module led_status_ch
   import led_status_pkg::*;
#(
   parameter int PERIOD_W      = DEF_PERIOD_W,
   parameter int STRETCH_TICKS = DEF_STRETCH_TICKS
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                i_act,
   input  logic                i_evtMask,
   input  logic                i_tick,
   input  logic                i_wrEn,
   input  led_mode_t           i_mode,
   input  logic [PERIOD_W-1:0] i_period,
`ifdef LED_PWM_EN
   input  logic [3:0]          i_duty,
   input  logic [3:0]          i_pwmCnt,
`endif
   output logic                o_lit
);

   localparam int STR_W = (STRETCH_TICKS > 0) ? $clog2(STRETCH_TICKS + 1) : 1;

   logic                r_sync1;
   logic                r_sync2;
   logic                r_prev;
   led_mode_t           r_mode;
   logic [PERIOD_W-1:0] r_period;
   logic [PERIOD_W-1:0] r_cnt;
   logic                r_phase;
   logic [STR_W-1:0]    r_stretch;
   logic                w_event;
   logic [PERIOD_W-1:0] w_limit;
   logic                w_modeLit;
`ifdef LED_PWM_EN
   logic [3:0]          r_duty;
`endif

   // Synchroniser plus one history flop; deliberately not reset, the
   // start-up garbage is hidden by i_evtMask instead.
   always_ff @(posedge clk) begin
      r_sync1 <= i_act;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
   end

   assign w_event = (r_sync2 ^ r_prev) & ~i_evtMask;

   // A period of 0 behaves like 1 so the counter always wraps.
   assign w_limit = (r_period == '0) ? '0 : (r_period - PERIOD_W'(1));

   // Channel state. A write restarts the channel from a clean state; an
   // event beats a coincident tick so a retrigger always gets full length.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mode    <= MODE_OFF;
         r_period  <= '0;
         r_cnt     <= '0;
         r_phase   <= 1'b0;
         r_stretch <= '0;
`ifdef LED_PWM_EN
         r_duty    <= 4'hF;
`endif
      end else if (i_wrEn) begin
         r_mode    <= i_mode;
         r_period  <= i_period;
         r_cnt     <= '0;
         r_phase   <= 1'b0;
         r_stretch <= '0;
`ifdef LED_PWM_EN
         r_duty    <= i_duty;
`endif
      end else begin
         if ((r_mode == MODE_BLINK) && i_tick) begin
            if (r_cnt == w_limit) begin
               r_cnt   <= '0;
               r_phase <= ~r_phase;
            end else begin
               r_cnt   <= r_cnt + PERIOD_W'(1);
            end
         end
         if (w_event) begin
            r_stretch <= STR_W'(STRETCH_TICKS);
         end else if (i_tick && (r_stretch != '0)) begin
            r_stretch <= r_stretch - STR_W'(1);
         end
      end
   end

   // Mode decides which internal state drives the LED.
   always_comb begin
      w_modeLit = 1'b0;
      case (r_mode)
         MODE_OFF:      w_modeLit = 1'b0;
         MODE_ON:       w_modeLit = 1'b1;
         MODE_BLINK:    w_modeLit = r_phase;
         MODE_ACTIVITY: w_modeLit = (r_stretch != '0);
         default:       w_modeLit = 1'b0;
      endcase
   end

`ifdef LED_PWM_EN
   assign o_lit = w_modeLit & (i_pwmCnt < r_duty);
`else
   assign o_lit = w_modeLit;
`endif

endmodule

// File: rtl/led_status_ctrl.sv
// -----------------------------------------------------------------------------
// led_status_ctrl
// Multi-channel LED status controller: shared tick prescaler, NUM_CH
// led_status_ch channels and the registered LED output stage.
// Optional feature macro: LED_PWM_EN adds a 4-bit PWM dimmer (cfg_duty on the
// configuration interface, per-channel duty register, shared PWM counter).
// Ports:
//   clk     : sole clock
//   rst     : synchronous active-high reset
//   cfg_if  : configuration write bus (led_status_ctrl_if.slave)
//   act_i   : asynchronous activity inputs, one per channel
//   led_o   : registered LED drive, lit level is ~ACTIVE_LOW
//   tick_o  : one-cycle pulse on each prescaler wrap
// -----------------------------------------------------------------------------
module led_status_ctrl
   import led_status_pkg::*;
#(
   parameter int NUM_CH        = 6,
   parameter int PRESCALE      = DEF_PRESCALE,
   parameter int PERIOD_W      = DEF_PERIOD_W,
   parameter int STRETCH_TICKS = DEF_STRETCH_TICKS,
   parameter bit ACTIVE_LOW    = 1'b1
)(
   input  logic              clk,
   input  logic              rst,
   led_status_ctrl_if.slave  cfg_if,
   input  logic [NUM_CH-1:0] act_i,
   output logic [NUM_CH-1:0] led_o,
   output logic              tick_o
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PS_W-1:0]   r_psCnt;
   logic              w_tick;
   logic [1:0]        r_maskCnt;
   logic              w_evtMask;
   logic [NUM_CH-1:0] w_lit;
`ifdef LED_PWM_EN
   logic [3:0]        r_pwmCnt;
`endif

   assign w_tick = (r_psCnt == PS_W'(PRESCALE - 1));
   assign tick_o = w_tick & ~rst;

   // Tick prescaler, wraps to zero on the tick cycle.
   always_ff @(posedge clk) begin
      if (rst || w_tick) begin
         r_psCnt <= '0;
      end else begin
         r_psCnt <= r_psCnt + PS_W'(1);
      end
   end

   // Event mask covers reset plus the two cycles the unreset synchronisers
   // need to flush whatever they held before reset released.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_maskCnt <= 2'd2;
      end else if (r_maskCnt != 2'd0) begin
         r_maskCnt <= r_maskCnt - 2'd1;
      end
   end

   assign w_evtMask = rst | (r_maskCnt != 2'd0);

`ifdef LED_PWM_EN
   // Free-running PWM counter shared by all channels.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pwmCnt <= 4'd0;
      end else begin
         r_pwmCnt <= r_pwmCnt + 4'd1;
      end
   end
`endif

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic w_wrEn;

      // Out-of-range channel indices never match, so such writes are dropped.
      assign w_wrEn = cfg_if.cfg_we && (cfg_if.cfg_ch == CH_W'(gi));

      led_status_ch #(
         .PERIOD_W      (PERIOD_W),
         .STRETCH_TICKS (STRETCH_TICKS)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .i_act     (act_i[gi]),
         .i_evtMask (w_evtMask),
         .i_tick    (w_tick),
         .i_wrEn    (w_wrEn),
         .i_mode    (cfg_if.cfg_mode),
         .i_period  (cfg_if.cfg_period),
`ifdef LED_PWM_EN
         .i_duty    (cfg_if.cfg_duty),
         .i_pwmCnt  (r_pwmCnt),
`endif
         .o_lit     (w_lit[gi])
      );
   end

   // Output register applies the LED polarity.
   always_ff @(posedge clk) begin
      if (rst) begin
         led_o <= {NUM_CH{ACTIVE_LOW}};
      end else begin
         led_o <= w_lit ^ {NUM_CH{ACTIVE_LOW}};
      end
   end

endmodule

// File: tb/tb_led_status_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_status_ctrl
// Self-checking bench for led_status_ctrl (PRESCALE=4, STRETCH_TICKS=3,
// NUM_CH=6, ACTIVE_LOW=1). A behavioural model computes LED and tick outputs
// from elapsed ticks and cycles; directed scenarios are followed by random
// configuration, activity and reset traffic.
// -----------------------------------------------------------------------------
module tb_led_status_ctrl;
   import led_status_pkg::*;

   localparam int NUM_CH        = 6;
   localparam int PRESCALE      = 4;
   localparam int PERIOD_W      = 10;
   localparam int STRETCH_TICKS = 3;
   localparam bit ACTIVE_LOW    = 1'b1;
`ifdef LED_PWM_EN
   localparam bit PWM_ON = 1'b1;
`else
   localparam bit PWM_ON = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NUM_CH-1:0] act_i = '0;
   logic [NUM_CH-1:0] led_o;
   logic              tick_o;
   logic [3:0]        cfgDuty = 4'hF;

   int testsRun    = 0;
   int testsFailed = 0;
   bit done        = 1'b0;

   led_status_ctrl_if #(.NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W)) cfgIf();

`ifdef LED_PWM_EN
   assign cfgIf.cfg_duty = cfgDuty;
`endif

   led_status_ctrl #(
      .NUM_CH        (NUM_CH),
      .PRESCALE      (PRESCALE),
      .PERIOD_W      (PERIOD_W),
      .STRETCH_TICKS (STRETCH_TICKS),
      .ACTIVE_LOW    (ACTIVE_LOW)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .cfg_if (cfgIf),
      .act_i  (act_i),
      .led_o  (led_o),
      .tick_o (tick_o)
   );

   always #5 clk = ~clk;

   // Reference model: channel behaviour expressed as ticks elapsed since the
   // last write or last activity event, plus a delay line for act_i.
   int                mMode      [NUM_CH];
   int                mPeriod    [NUM_CH];
   int                mBlinkTicks[NUM_CH];
   bit                mEvSeen    [NUM_CH];
   int                mEvTicks   [NUM_CH];
   int                mDuty      [NUM_CH];
   logic [NUM_CH-1:0] h1 = '0;
   logic [NUM_CH-1:0] h2 = '0;
   logic [NUM_CH-1:0] h3 = '0;
   int                sinceRel   = 0;
   bit                modelValid = 1'b0;
   logic [NUM_CH-1:0] expLed     = '1;

   function automatic bit modelTick();
      return !rst && ((sinceRel % PRESCALE) == PRESCALE - 1);
   endfunction

   function automatic bit modelLit(int i);
      bit on;
      int p;
      p = (mPeriod[i] == 0) ? 1 : mPeriod[i];
      case (mMode[i])
         0:       on = 1'b0;
         1:       on = 1'b1;
         2:       on = ((mBlinkTicks[i] / p) % 2) == 1;
         default: on = mEvSeen[i] && (mEvTicks[i] < STRETCH_TICKS);
      endcase
      if (PWM_ON) on = on && ((sinceRel % 16) < mDuty[i]);
      return on;
   endfunction

   // Advance the model by one clock edge using the inputs of the ending cycle.
   always @(posedge clk) begin
      logic [NUM_CH-1:0] ev;
      logic [NUM_CH-1:0] lit;
      bit                tk;
      tk  = modelTick();
      ev  = (h2 ^ h3) & {NUM_CH{!(rst || sinceRel < 2)}};
      for (int i = 0; i < NUM_CH; i++) lit[i] = modelLit(i);
      expLed = rst ? {NUM_CH{ACTIVE_LOW}} : (lit ^ {NUM_CH{ACTIVE_LOW}});
      for (int i = 0; i < NUM_CH; i++) begin
         if (rst) begin
            mMode[i] = 0; mPeriod[i] = 0; mBlinkTicks[i] = 0;
            mEvSeen[i] = 1'b0; mEvTicks[i] = 0; mDuty[i] = 15;
         end else if (cfgIf.cfg_we && (int'(cfgIf.cfg_ch) == i)) begin
            mMode[i]       = int'(cfgIf.cfg_mode);
            mPeriod[i]     = int'(cfgIf.cfg_period);
            mDuty[i]       = int'(cfgDuty);
            mBlinkTicks[i] = 0;
            mEvSeen[i]     = 1'b0;
            mEvTicks[i]    = 0;
         end else begin
            if (tk) mBlinkTicks[i]++;
            if (ev[i]) begin
               mEvSeen[i]  = 1'b1;
               mEvTicks[i] = 0;
            end else if (tk) begin
               mEvTicks[i]++;
            end
         end
      end
      h3 = h2;
      h2 = h1;
      h1 = act_i;
      sinceRel = rst ? 0 : sinceRel + 1;
      if (rst) modelValid = 1'b1;
   end

   task automatic checkOutput(string name, logic [31:0] got, logic [31:0] want);
      testsRun++;
      if (got !== want) begin
         testsFailed++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, got, want);
      end
   endtask

   // Every-cycle comparison against the model, mid-cycle.
   always @(negedge clk) begin
      if (modelValid && !done) begin
         checkOutput("led_o_model", led_o, expLed);
         checkOutput("tick_o_model", tick_o, modelTick());
      end
   end

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(int ch, led_mode_t mode, int period, int duty);
      cfgIf.cfg_we     = 1'b1;
      cfgIf.cfg_ch     = 3'(ch);
      cfgIf.cfg_mode   = mode;
      cfgIf.cfg_period = PERIOD_W'(period);
      cfgDuty          = 4'(duty);
      stepCycle();
      cfgIf.cfg_we     = 1'b0;
   endtask

   initial begin
      int lowCnt;
      int toggles;
      logic prevBit;

      cfgIf.cfg_we     = 1'b0;
      cfgIf.cfg_ch     = '0;
      cfgIf.cfg_mode   = MODE_OFF;
      cfgIf.cfg_period = '0;

      // Reset held for three edges, output must sit at the unlit level.
      stepCycle();
      checkOutput("reset_led", led_o, 32'h3F);
      stepCycle();
      stepCycle();
      rst = 1'b0;

      // Tick pattern after release: every 4th cycle starting with cycle 3.
      for (int k = 0; k < 8; k++) begin
         checkOutput("tick_after_release", tick_o, (k % 4) == 3);
         stepCycle();
      end

      // Activity edge whose detection cycle coincides with a tick.
      applyStimulus(1, MODE_ACTIVITY, 0, 15);
      for (int k = 0; k < 4; k++) begin
         if ((sinceRel % 4) == 1) break;
         stepCycle();
      end
      act_i[1] = ~act_i[1];
      lowCnt = 0;
      for (int k = 1; k <= 20; k++) begin
         stepCycle();
`ifndef LED_PWM_EN
         if (k == 3) checkOutput("act_before_latency", led_o[1], 1);
         if (k == 4) checkOutput("act_latency", led_o[1], 0);
`endif
         if (led_o[1] == 1'b0) lowCnt++;
      end
`ifndef LED_PWM_EN
      checkOutput("stretch_coincident_len", lowCnt, 12);
`endif

      // Retrigger mid-stretch.
      act_i[1] = ~act_i[1];
      repeat (6) stepCycle();
      act_i[1] = ~act_i[1];
      repeat (24) stepCycle();

      // Blink channel 0, half-period 2 ticks = 8 clocks.
      applyStimulus(0, MODE_BLINK, 2, 15);
      for (int k = 0; k < 6; k++) begin
`ifndef LED_PWM_EN
         checkOutput("blink_initial_unlit", led_o[0], 1);
`endif
         stepCycle();
      end
      repeat (6) stepCycle();
      toggles = 0;
      prevBit = led_o[0];
      for (int k = 0; k < 32; k++) begin
         stepCycle();
         if (led_o[0] != prevBit) toggles++;
         prevBit = led_o[0];
      end
`ifndef LED_PWM_EN
      checkOutput("blink_toggles_32cyc", toggles, 4);
`endif

      // Out-of-range channel write must change nothing.
      applyStimulus(7, MODE_ON, 5, 0);
      repeat (10) stepCycle();

      // Rewrite a blinking channel while it is lit.
      applyStimulus(2, MODE_BLINK, 1, 15);
      for (int k = 0; k < 20; k++) begin
         if (modelLit(2)) break;
         stepCycle();
      end
      applyStimulus(2, MODE_BLINK, 3, 15);
`ifndef LED_PWM_EN
      checkOutput("rewrite_still_lit", led_o[2], 0);
`endif
      stepCycle();
`ifndef LED_PWM_EN
      checkOutput("rewrite_unlit", led_o[2], 1);
`endif
      repeat (10) stepCycle();

`ifdef LED_PWM_EN
      applyStimulus(3, MODE_ON, 0, 4);
      stepCycle();
      lowCnt = 0;
      for (int k = 0; k < 16; k++) begin
         stepCycle();
         if (led_o[3] == 1'b0) lowCnt++;
      end
      checkOutput("pwm_duty4_low", lowCnt, 4);
      applyStimulus(3, MODE_ON, 0, 0);
      stepCycle();
      lowCnt = 0;
      for (int k = 0; k < 16; k++) begin
         stepCycle();
         if (led_o[3] == 1'b0) lowCnt++;
      end
      checkOutput("pwm_duty0_low", lowCnt, 0);
`endif

      // Reset in the middle of a stretch, with activity toggling through
      // reset and release.
      act_i[1] = ~act_i[1];
      repeat (4) stepCycle();
      rst = 1'b1;
      stepCycle();
      checkOutput("rst_mid_activity", led_o, 32'h3F);
      for (int k = 0; k < 3; k++) begin
         act_i[1] = ~act_i[1];
         stepCycle();
      end
      rst = 1'b0;
      act_i[1] = ~act_i[1];
      applyStimulus(1, MODE_ACTIVITY, 0, 15);
      act_i[1] = ~act_i[1];
      stepCycle();
      act_i[1] = ~act_i[1];
      repeat (24) stepCycle();

      // Random traffic checked by the model every cycle.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            cfgIf.cfg_we     = 1'b1;
            cfgIf.cfg_ch     = 3'($urandom_range(0, 7));
            cfgIf.cfg_mode   = led_mode_t'($urandom_range(0, 3));
            cfgIf.cfg_period = PERIOD_W'($urandom_range(0, 3));
            cfgDuty          = 4'($urandom_range(0, 15));
         end else begin
            cfgIf.cfg_we = 1'b0;
         end
         for (int b = 0; b < NUM_CH; b++) begin
            if ($urandom_range(0, 9) == 0) act_i[b] = ~act_i[b];
         end
         if (rst) rst = ($urandom_range(0, 1) == 0);
         else     rst = ($urandom_range(0, 399) == 0);
         stepCycle();
      end

      cfgIf.cfg_we = 1'b0;
      stepCycle();
      done = 1'b1;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
